// File: rtl/id_stage_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg : shared definitions for the MIPS decode stage (id_stage_pipe).
//   - Opcode constants for the supported instruction classes.
//   - ALU operation-class encodings passed to EX.
//   - ctrl_t : packed control bundle carried in the ID/EX register.
// -----------------------------------------------------------------------------
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic       regwrite;
    logic       regdst;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// -----------------------------------------------------------------------------
// id_regfile : two-read / one-write register file for the decode stage.
//   Register 0 is hard-wired to zero. A read of the register being written in
//   the same cycle returns the write data (write-first bypass), so write-back
//   and decode can overlap without an extra forwarding path.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears all regs)
//   we_i, waddr_i, wdata_i write port
//   raddr_a_i, raddr_b_i   read addresses
//   rdata_a_o, rdata_b_o   combinational read data
// -----------------------------------------------------------------------------
module id_regfile #(
  parameter int REG_WIDTH     = 8,
  parameter int REG_DIR_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [REG_DIR_WIDTH-1:0] waddr_i,
  input  logic [REG_WIDTH-1:0]     wdata_i,
  input  logic [REG_DIR_WIDTH-1:0] raddr_a_i,
  input  logic [REG_DIR_WIDTH-1:0] raddr_b_i,
  output logic [REG_WIDTH-1:0]     rdata_a_o,
  output logic [REG_WIDTH-1:0]     rdata_b_o
);

  localparam int DEPTH = 1 << REG_DIR_WIDTH;

  // Register 0 has no storage; it is synthesised as a constant.
  logic [REG_WIDTH-1:0] regs_q [1:DEPTH-1];

  // NOTE: the array is reset on purpose: a mid-run reset must leave every
  // register reading zero, which rules out a reset-less RAM macro here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [REG_WIDTH-1:0] read_port(input logic [REG_DIR_WIDTH-1:0] addr);
    if (addr == '0)                    return '0;
    else if (we_i && (waddr_i == addr)) return wdata_i;
    else                               return regs_q[addr];
  endfunction

  assign rdata_a_o = read_port(raddr_a_i);
  assign rdata_b_o = read_port(raddr_b_i);

endmodule

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe : MIPS instruction-decode stage with its own ID/EX register.
//   Decodes the IF/ID instruction, reads the register file, forwards EX/MEM
//   results into the operands, detects load-use (and branch-compare) hazards,
//   resolves beq in ID and registers the decoded bundle for EX.
// Optional feature (macro ID_BNE_EN): when defined, opcode 000101 (bne) is a
//   branch taken on unequal operands; when undefined it decodes as a NOP.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ifid_valid, instr, pc_next     instruction and PC+4 from IF/ID
//   wb_we, wb_reg, wb_data         write-back port into the register file
//   ex_regwrite, ex_memread, ex_rd, ex_result   state of the EX instruction
//   mem_regwrite, mem_rd, mem_result            state of the MEM instruction
//   stall, if_flush, branch_target combinational hazard / branch outputs
//   idex_*                         registered ID/EX bundle
// -----------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int REG_WIDTH     = 8,
  parameter int REG_DIR_WIDTH = 3,
  parameter int IMM_IN_WIDTH  = 16,
  parameter int PC_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ifid_valid,
  input  logic [31:0]              instr,
  input  logic [PC_WIDTH-1:0]      pc_next,
  input  logic                     wb_we,
  input  logic [REG_DIR_WIDTH-1:0] wb_reg,
  input  logic [REG_WIDTH-1:0]     wb_data,
  input  logic                     ex_regwrite,
  input  logic                     ex_memread,
  input  logic [REG_DIR_WIDTH-1:0] ex_rd,
  input  logic [REG_WIDTH-1:0]     ex_result,
  input  logic                     mem_regwrite,
  input  logic [REG_DIR_WIDTH-1:0] mem_rd,
  input  logic [REG_WIDTH-1:0]     mem_result,
  output logic                     stall,
  output logic                     if_flush,
  output logic [PC_WIDTH-1:0]      branch_target,
  output logic                     idex_valid,
  output logic [REG_WIDTH-1:0]     idex_rd1,
  output logic [REG_WIDTH-1:0]     idex_rd2,
  output logic [REG_WIDTH-1:0]     idex_imm,
  output logic [REG_DIR_WIDTH-1:0] idex_rs,
  output logic [REG_DIR_WIDTH-1:0] idex_rt,
  output logic [REG_DIR_WIDTH-1:0] idex_rd,
  output logic                     idex_alusrc,
  output logic                     idex_memtoreg,
  output logic                     idex_memwrite,
  output logic                     idex_memread,
  output logic                     idex_regwrite,
  output logic                     idex_regdst,
  output logic [1:0]               idex_aluop
);

  import id_pkg::*;

  // ---------------------------------------------------------------- fields
  logic [5:0]               opcode;
  logic [REG_DIR_WIDTH-1:0] rs, rt, rd;
  logic signed [31:0]       imm_sext32;
  logic [31:0]              br_offset;
  logic [REG_WIDTH-1:0]     imm;

  assign opcode     = instr[31:26];
  assign rs         = instr[21 +: REG_DIR_WIDTH];
  assign rt         = instr[16 +: REG_DIR_WIDTH];
  assign rd         = instr[11 +: REG_DIR_WIDTH];
  assign imm_sext32 = 32'(signed'(instr[IMM_IN_WIDTH-1:0]));
  assign imm        = imm_sext32[REG_WIDTH-1:0];
  assign br_offset  = imm_sext32 << 2;

  // Wraps modulo 2**PC_WIDTH by truncation.
  assign branch_target = pc_next + br_offset[PC_WIDTH-1:0];

  // Bits not consumed under every parameter set (funct, shamt, upper sext).
  logic unused_bits;
  assign unused_bits = ^{instr, imm_sext32, br_offset};

  // ---------------------------------------------------------- register file
  logic [REG_WIDTH-1:0] rf_a, rf_b;

  id_regfile #(
    .REG_WIDTH     (REG_WIDTH),
    .REG_DIR_WIDTH (REG_DIR_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we),
    .waddr_i   (wb_reg),
    .wdata_i   (wb_data),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  // ------------------------------------------------------------- forwarding
  // EX beats MEM because it is the younger producer. A load in EX has no
  // data yet, so it is never forwarded; the stall below covers that case.
  function automatic logic [REG_WIDTH-1:0] fwd(input logic [REG_DIR_WIDTH-1:0] src,
                                               input logic [REG_WIDTH-1:0]     rf_val);
    if (ex_regwrite && !ex_memread && (ex_rd == src) && (src != '0)) return ex_result;
    else if (mem_regwrite && (mem_rd == src) && (src != '0))         return mem_result;
    else                                                             return rf_val;
  endfunction

  logic [REG_WIDTH-1:0] op1, op2;
  assign op1 = fwd(rs, rf_a);
  assign op2 = fwd(rt, rf_b);

  // ---------------------------------------------------------------- decode
  ctrl_t ctrl;
  logic  is_beq, is_bne, is_branch;

  // NOTE: every output gets a default before the case, so opcodes that match
  // no item cannot leave a variable unassigned and infer a latch.
  always_comb begin
    ctrl   = '0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      OP_ADDI: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.aluop = ALUOP_SUB;
        is_beq     = 1'b1;
      end
`ifdef ID_BNE_EN
      OP_BNE: begin
        ctrl.aluop = ALUOP_SUB;
        is_bne     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign is_branch = is_beq | is_bne;

  // --------------------------------------------------------------- hazards
  logic src_hit_ex, load_use, branch_dep;

  assign src_hit_ex = (ex_rd != '0) && ((ex_rd == rs) || (ex_rd == rt));
  assign load_use   = ex_memread && src_hit_ex;
  // The branch compares in ID, before an EX ALU result is registered.
  assign branch_dep = is_branch && ex_regwrite && src_hit_ex;

  assign stall    = !rst && ifid_valid && (load_use || branch_dep);
  assign if_flush = !rst && ifid_valid && !stall &&
                    ((is_beq && (op1 == op2)) || (is_bne && (op1 != op2)));

  // ------------------------------------------------------- ID/EX register
  ctrl_t                    ctrl_d, ctrl_q;
  logic                     valid_d, valid_q;
  logic [REG_WIDTH-1:0]     rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [REG_DIR_WIDTH-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;

  // Branches are fully resolved here, so they leave a bubble for EX.
  always_comb begin
    ctrl_d  = '0;
    valid_d = 1'b0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    if (ifid_valid && !stall && !is_branch) begin
      ctrl_d  = ctrl;
      valid_d = 1'b1;
      rd1_d   = op1;
      rd2_d   = op2;
      imm_d   = imm;
      rs_d    = rs;
      rt_d    = rt;
      rd_d    = rd;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  assign idex_valid    = valid_q;
  assign idex_rd1      = rd1_q;
  assign idex_rd2      = rd2_q;
  assign idex_imm      = imm_q;
  assign idex_rs       = rs_q;
  assign idex_rt       = rt_q;
  assign idex_rd       = rd_q;
  assign idex_alusrc   = ctrl_q.alusrc;
  assign idex_memtoreg = ctrl_q.memtoreg;
  assign idex_memwrite = ctrl_q.memwrite;
  assign idex_memread  = ctrl_q.memread;
  assign idex_regwrite = ctrl_q.regwrite;
  assign idex_regdst   = ctrl_q.regdst;
  assign idex_aluop    = ctrl_q.aluop;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe : directed self-checking bench for id_stage_pipe with the
// default parameters (8-bit data, 8 registers, 16-bit immediate, 8-bit PC).
// Inputs change 1 ns after a rising edge; outputs are sampled before the next.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifid_valid;
  logic [31:0] instr;
  logic [7:0]  pc_next;
  logic        wb_we;
  logic [2:0]  wb_reg;
  logic [7:0]  wb_data;
  logic        ex_regwrite, ex_memread;
  logic [2:0]  ex_rd;
  logic [7:0]  ex_result;
  logic        mem_regwrite;
  logic [2:0]  mem_rd;
  logic [7:0]  mem_result;
  logic        stall, if_flush;
  logic [7:0]  branch_target;
  logic        idex_valid;
  logic [7:0]  idex_rd1, idex_rd2, idex_imm;
  logic [2:0]  idex_rs, idex_rt, idex_rd;
  logic        idex_alusrc, idex_memtoreg, idex_memwrite, idex_memread;
  logic        idex_regwrite, idex_regdst;
  logic [1:0]  idex_aluop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .ifid_valid    (ifid_valid),
    .instr         (instr),
    .pc_next       (pc_next),
    .wb_we         (wb_we),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .ex_regwrite   (ex_regwrite),
    .ex_memread    (ex_memread),
    .ex_rd         (ex_rd),
    .ex_result     (ex_result),
    .mem_regwrite  (mem_regwrite),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .stall         (stall),
    .if_flush      (if_flush),
    .branch_target (branch_target),
    .idex_valid    (idex_valid),
    .idex_rd1      (idex_rd1),
    .idex_rd2      (idex_rd2),
    .idex_imm      (idex_imm),
    .idex_rs       (idex_rs),
    .idex_rt       (idex_rt),
    .idex_rd       (idex_rd),
    .idex_alusrc   (idex_alusrc),
    .idex_memtoreg (idex_memtoreg),
    .idex_memwrite (idex_memwrite),
    .idex_memread  (idex_memread),
    .idex_regwrite (idex_regwrite),
    .idex_regdst   (idex_regdst),
    .idex_aluop    (idex_aluop)
  );

  // Control packed as {alusrc,memtoreg,memwrite,memread,regwrite,regdst,aluop}.
  logic [7:0] ctrl_obs;
  assign ctrl_obs = {idex_alusrc, idex_memtoreg, idex_memwrite, idex_memread,
                     idex_regwrite, idex_regdst, idex_aluop};

  localparam logic [7:0] CTRL_R    = 8'b0000_1110;
  localparam logic [7:0] CTRL_LW   = 8'b1101_1000;
  localparam logic [7:0] CTRL_SW   = 8'b1010_0000;
  localparam logic [7:0] CTRL_ADDI = 8'b1000_1000;
  localparam logic [7:0] CTRL_NONE = 8'b0000_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_add(input int d, input int s, input int t);
    return {6'b000000, 5'(s), 5'(t), 5'(d), 5'b00000, 6'h20};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int s, input int t,
                                       input logic [15:0] imm16);
    return {op, 5'(s), 5'(t), imm16};
  endfunction

  task automatic clear_pipe();
    ex_regwrite  = 1'b0;
    ex_memread   = 1'b0;
    ex_rd        = '0;
    ex_result    = '0;
    mem_regwrite = 1'b0;
    mem_rd       = '0;
    mem_result   = '0;
    wb_we        = 1'b0;
    wb_reg       = '0;
    wb_data      = '0;
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [7:0] v);
    ifid_valid = 1'b0;
    wb_we      = 1'b1;
    wb_reg     = r;
    wb_data    = v;
    tick();
    wb_we      = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    ifid_valid = 1'b0;
    instr      = '0;
    pc_next    = '0;
    clear_pipe();

    // --- reset: hazard outputs forced low even with a load-use pattern
    tick();
    ifid_valid = 1'b1;
    instr      = r_add(5, 2, 1);
    ex_memread = 1'b1;
    ex_rd      = 3'd2;
    #1;
    check("stall_in_rst", 32'(stall), 0);
    tick();
    check("valid_rst", 32'(idex_valid), 0);
    check("ctrl_rst", 32'(ctrl_obs), 0);
    clear_pipe();
    ifid_valid = 1'b0;
    rst        = 1'b0;
    #1;
    check("stall_idle", 32'(stall), 0);
    check("flush_idle", 32'(if_flush), 0);

    // --- every register reads zero after reset
    ifid_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr = r_add(7, i, i);
      tick();
      check($sformatf("rf_zero_a%0d", i), 32'(idex_rd1), 0);
      check($sformatf("rf_zero_b%0d", i), 32'(idex_rd2), 0);
    end

    // --- write-first bypass: r3=0x5A written while add r4,r3,r3 decodes
    wb_we   = 1'b1;
    wb_reg  = 3'd3;
    wb_data = 8'h5A;
    instr   = r_add(4, 3, 3);
    tick();
    wb_we = 1'b0;
    check("byp_rd1", 32'(idex_rd1), 32'h5A);
    check("byp_rd2", 32'(idex_rd2), 32'h5A);
    check("byp_valid", 32'(idex_valid), 1);
    check("byp_ctrl", 32'(ctrl_obs), 32'(CTRL_R));
    check("byp_rd", 32'(idex_rd), 4);
    tick();
    check("rf_hold_r3", 32'(idex_rd1), 32'h5A);

    // --- load-use stall, then issue once EX is cleared
    ex_memread  = 1'b1;
    ex_regwrite = 1'b1;
    ex_rd       = 3'd2;
    instr       = r_add(5, 2, 1);
    #1;
    check("lu_stall", 32'(stall), 1);
    check("lu_noflush", 32'(if_flush), 0);
    tick();
    check("lu_bubble", 32'(idex_valid), 0);
    check("lu_bubble_ctrl", 32'(ctrl_obs), 0);
    clear_pipe();
    #1;
    check("lu_release", 32'(stall), 0);
    tick();
    check("lu_issue", 32'(idex_valid), 1);
    check("lu_issue_rd", 32'(idex_rd), 5);
    check("lu_issue_rs", 32'(idex_rs), 2);
    check("lu_issue_rt", 32'(idex_rt), 1);

    // --- forwarding priority and r0 exclusion
    ex_regwrite  = 1'b1;
    ex_rd        = 3'd1;
    ex_result    = 8'h11;
    mem_regwrite = 1'b1;
    mem_rd       = 3'd1;
    mem_result   = 8'h22;
    instr        = r_add(6, 1, 3);
    tick();
    check("fwd_ex_wins", 32'(idex_rd1), 32'h11);
    check("fwd_rf_other", 32'(idex_rd2), 32'h5A);
    ex_regwrite = 1'b0;
    tick();
    check("fwd_mem", 32'(idex_rd1), 32'h22);
    clear_pipe();
    ex_regwrite = 1'b1;
    ex_rd       = 3'd0;
    ex_result   = 8'hFF;
    instr       = r_add(6, 0, 0);
    tick();
    check("fwd_r0_none", 32'(idex_rd1), 0);
    clear_pipe();

    // --- I-type decode and immediate truncation
    instr = i_op(6'b001000, 1, 7, 16'h0085);
    tick();
    check("addi_ctrl", 32'(ctrl_obs), 32'(CTRL_ADDI));
    check("addi_imm", 32'(idex_imm), 32'h85);
    instr = i_op(6'b100011, 3, 2, 16'hFFFC);
    tick();
    check("lw_ctrl", 32'(ctrl_obs), 32'(CTRL_LW));
    check("lw_imm", 32'(idex_imm), 32'hFC);
    instr = i_op(6'b101011, 3, 2, 16'h0004);
    tick();
    check("sw_ctrl", 32'(ctrl_obs), 32'(CTRL_SW));
    instr = i_op(6'b111111, 3, 2, 16'h0004);
    tick();
    check("nop_valid", 32'(idex_valid), 1);
    check("nop_ctrl", 32'(ctrl_obs), 32'(CTRL_NONE));

    // --- ifid_valid=0 gives a bubble
    ifid_valid = 1'b0;
    instr      = r_add(4, 3, 3);
    tick();
    check("invalid_bubble", 32'(idex_valid), 0);

    // --- beq taken / not taken, target arithmetic
    wb_write(3'd1, 8'h07);
    wb_write(3'd2, 8'h07);
    ifid_valid = 1'b1;
    pc_next    = 8'h20;
    instr      = i_op(6'b000100, 1, 2, 16'h0003);
    #1;
    check("beq_flush", 32'(if_flush), 1);
    check("beq_target", 32'(branch_target), 32'h2C);
    check("beq_nostall", 32'(stall), 0);
    tick();
    check("beq_bubble", 32'(idex_valid), 0);
    wb_we   = 1'b1;
    wb_reg  = 3'd2;
    wb_data = 8'h08;
    #1;
    check("beq_not_taken", 32'(if_flush), 0);
    tick();
    wb_we = 1'b0;
    instr = i_op(6'b000100, 1, 2, 16'hFFFF);
    #1;
    check("tgt_negative", 32'(branch_target), 32'h1C);
    pc_next = 8'hFC;
    instr   = i_op(6'b000100, 1, 2, 16'h0001);
    #1;
    check("tgt_wrap", 32'(branch_target), 32'h00);

    // --- beq dependent on EX ALU result: stall, and stall blocks the flush
    instr       = i_op(6'b000100, 1, 1, 16'h0003);
    ex_regwrite = 1'b1;
    ex_rd       = 3'd1;
    ex_result   = 8'h07;
    #1;
    check("beq_dep_stall", 32'(stall), 1);
    check("beq_dep_noflush", 32'(if_flush), 0);
    clear_pipe();
    #1;
    check("beq_self_flush", 32'(if_flush), 1);

    // --- bne (r1=0x07, r2=0x08)
    instr = i_op(6'b000101, 1, 2, 16'h0003);
    #1;
`ifdef ID_BNE_EN
    check("bne_flush", 32'(if_flush), 1);
    tick();
    check("bne_bubble", 32'(idex_valid), 0);
`else
    check("bne_nop_flush", 32'(if_flush), 0);
    tick();
    check("bne_nop_valid", 32'(idex_valid), 1);
    check("bne_nop_ctrl", 32'(ctrl_obs), 32'(CTRL_NONE));
`endif

    // --- reset mid-run clears the register file and ID/EX
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(idex_valid), 0);
    rst   = 1'b0;
    instr = r_add(4, 1, 3);
    tick();
    check("rst_mid_r1", 32'(idex_rd1), 0);
    check("rst_mid_r3", 32'(idex_rd2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised MIPS decode stage with its own registered ID/EX pipeline boundary.
- Contains the register file, main control decode, sign extension and branch-in-ID resolution.
- Adds EX/MEM-to-ID forwarding, load-use hazard detection with bubble insertion, and a registered ID/EX output bundle.
- Sits between the IF/ID register (upstream) and the EX stage (downstream).

Parameters:
- REG_WIDTH, 8, data width of registers, operands and forwarded results.
- REG_DIR_WIDTH, 3, register address width; register file depth is 2**REG_DIR_WIDTH.
- IMM_IN_WIDTH, 16, number of instr[15:0] bits that are sign-extended (1..16).
- PC_WIDTH, 8, byte-address PC width.

Ports:
- clk  in  1  stage clock.
- rst  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
- ifid_valid  in  1  IF/ID holds a real instruction.
- instr  in  32  instruction from IF/ID.
- pc_next  in  PC_WIDTH  PC+4 of the instruction in ID.
- wb_we  in  1  write-back enable.
- wb_reg  in  REG_DIR_WIDTH  write-back register address.
- wb_data  in  REG_WIDTH  write-back data.
- ex_regwrite, ex_memread  in  1 each  control bits of the instruction in EX.
- ex_rd  in  REG_DIR_WIDTH  destination register of the instruction in EX.
- ex_result  in  REG_WIDTH  ALU result in EX.
- mem_regwrite  in  1  control bit of the instruction in MEM.
- mem_rd  in  REG_DIR_WIDTH  destination register of the instruction in MEM.
- mem_result  in  REG_WIDTH  value being written by the instruction in MEM.
- stall  out  1  combinational; hold PC and IF/ID.
- if_flush  out  1  combinational; squash IF/ID on the next edge.
- branch_target  out  PC_WIDTH  combinational; pc_next + (sext(imm) << 2), modulo 2**PC_WIDTH.
- idex_valid  out  1  registered; ID/EX holds a real instruction.
- idex_rd1, idex_rd2  out  REG_WIDTH  registered forwarded operands.
- idex_imm  out  REG_WIDTH  registered sign-extended immediate.
- idex_rs, idex_rt, idex_rd  out  REG_DIR_WIDTH  registered register addresses.
- idex_alusrc, idex_memtoreg, idex_memwrite, idex_memread, idex_regwrite, idex_regdst  out  1 each  registered control.
- idex_aluop  out  2  registered ALU op class.

Behaviour:
- Field extraction:
  - rs = instr[21 +: REG_DIR_WIDTH], rt = instr[16 +: REG_DIR_WIDTH], rd = instr[11 +: REG_DIR_WIDTH].
  - imm = sign-extend instr[IMM_IN_WIDTH-1:0] to REG_WIDTH; truncate if REG_WIDTH < IMM_IN_WIDTH.
- Register file:
  - Register 0 reads 0 and ignores writes.
  - Written on the clk edge when wb_we=1.
  - Same-cycle read of wb_reg (nonzero, wb_we=1) returns wb_data (write-first bypass).
- Operand select, per source register, in priority order:
  - EX, when ex_regwrite, ex_rd==src, src!=0 and !ex_memread; returns ex_result.
  - MEM, when mem_regwrite, mem_rd==src, src!=0; returns mem_result.
  - Otherwise the register file.
- Control decode:
  - R-type 000000: regdst=1, regwrite=1, aluop=10.
  - lw 100011: alusrc=1, memtoreg=1, memread=1, regwrite=1, aluop=00.
  - sw 101011: alusrc=1, memwrite=1, aluop=00.
  - addi 001000: alusrc=1, regwrite=1, aluop=00.
  - beq 000100: aluop=01, no writes.
  - Any other opcode: all control 0, treated as a NOP.
- Load-use stall:
  - stall = ifid_valid & ex_memread & ex_rd!=0 & (ex_rd==rs | ex_rd==rt).
  - For beq, stall also asserts when ex_regwrite & ex_rd matches (EX result is not final in time for the compare). This is a one-cycle bubble.
- Branch:
  - Taken = beq & ifid_valid & !stall & (op1==op2), using forwarded operands.
  - if_flush = taken.
  - branch_target is always driven, regardless of opcode.
- ID/EX register, on each clk edge:
  - rst: all idex_* outputs = 0.
  - Else if stall, !ifid_valid, or beq: bubble. idex_valid=0 and all control=0; data fields are don't-care but driven 0. beq produces no EX work.
  - Else: load decoded fields, idex_valid=1.
- Latency: one cycle from instr to idex_*; stall, if_flush and branch_target are same-cycle.
- Simultaneous events:
  - stall dominates branch: no flush while stalled.
  - A wb write and an ID read of the same register are covered by the bypass.
  - With EX and MEM both matching, EX wins.
- Reset mid-operation: the register file clears to 0 on the rst edge. stall and if_flush are forced 0 while rst=1.

Optional Feature:
- Macro: ID_BNE_EN.
- Defined: opcode 000101 (bne) decodes like beq but is taken when op1!=op2; it uses the same stall and flush rules.
- Undefined: 000101 decodes as a NOP, never stalls and never flushes.

Decomposition:
- Package id_pkg holds:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE).
  - ALUop encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10).
  - A packed control-bundle typedef.
- One sub-module, id_regfile: register file with write-first bypass and synchronous reset.

Test Plan:
- Reset, then read all registers → every operand is 0; idex_valid=0; stall=0; if_flush=0.
- Write r3=0x5A via wb_we; same cycle decode add r4,r3,r3 → idex_rd1=idex_rd2=0x5A one edge later (bypass).
- EX: lw r2, ex_memread=1; ID: add r5,r2,r1 → stall=1 and a bubble (idex_valid=0). Next cycle with EX cleared → instruction issues.
- Forwarding priority: ex_rd=mem_rd=1, ex_result=0x11, mem_result=0x22 → operand 0x11. With ex_regwrite=0 → operand 0x22.
- beq r1,r2 with both operands =0x07, pc_next=0x20, imm=0x0003 → if_flush=1, branch_target=0x2C. With r2=0x08 → if_flush=0.
- With ID_BNE_EN defined, bne on unequal operands → if_flush=1. Without it → idex_valid=1, all control 0, if_flush=0.
